platform_button_pio: RTL and testbench

PLATFORM_BUTTON_PIO -- requirements
Module: platform_button_pio

---
 rtl/platform_button_pio.sv | 138 +++++++++++++
 tb/tb_platform_button_pio.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/platform_button_pio.sv
// platform_button_pio: Avalon-MM button PIO with synchronizers, edge capture and IRQ masking.
// Optional per-channel debounce is enabled with the PLATFORM_BUTTON_PIO_DEBOUNCE_EN macro. Rev 1.0
`default_nettype none

module platform_button_pio #(
  parameter int WIDTH           = 4,
  parameter int EDGE_TYPE       = 0,
  parameter int IRQ_MODE        = 1,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             chipselect,
  input  logic [1:0]       address,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [WIDTH-1:0] data;
  logic [WIDTH-1:0] prev;
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] edge_capture;
  logic [WIDTH-1:0] edge_det;
  logic [WIDTH-1:0] clr;
  logic             wr_mask;
  logic             wr_capture;
  logic             unused_wdata;

  assign unused_wdata = ^writedata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= in_port;
      sync2 <= sync1;
    end
  end

`ifdef PLATFORM_BUTTON_PIO_DEBOUNCE_EN
  localparam logic [15:0] CNT_LAST = 16'(DEBOUNCE_CYCLES - 1);

  // Previous synchronized value lets each channel restart its count on any input change.
  logic [WIDTH-1:0] sync_last;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_last <= '0;
    end else begin
      sync_last <= sync2;
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_debounce
    logic [15:0] cnt;
    logic        deb;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        cnt <= '0;
        deb <= 1'b0;
      end else if ((sync2[i] == deb) || (sync2[i] != sync_last[i])) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        deb <= sync2[i];
        cnt <= '0;
      end else begin
        cnt <= cnt + 16'd1;
      end
    end

    assign data[i] = deb;
  end
`else
  logic [31:0] unused_cfg;

  assign unused_cfg = 32'(DEBOUNCE_CYCLES);
  assign data       = sync2;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev <= '0;
    end else begin
      prev <= data;
    end
  end

  always_comb begin
    edge_det = '0;
    case (EDGE_TYPE)
      0:       edge_det = data & ~prev;
      1:       edge_det = ~data & prev;
      default: edge_det = data ^ prev;
    endcase
  end

  assign wr_mask    = chipselect && !write_n && (address == 2'd2);
  assign wr_capture = chipselect && !write_n && (address == 2'd3);
  assign clr        = wr_capture ? writedata[WIDTH-1:0] : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_mask     <= '0;
      edge_capture <= '0;
    end else begin
      if (wr_mask) begin
        irq_mask <= writedata[WIDTH-1:0];
      end
      // A new edge overrides a same-cycle clear of that bit.
      edge_capture <= (edge_capture & ~clr) | edge_det;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= '0;
    end else begin
      case (address)
        2'd0:    readdata <= 32'(data);
        2'd2:    readdata <= 32'(irq_mask);
        2'd3:    readdata <= 32'(edge_capture);
        default: readdata <= '0;
      endcase
    end
  end

  assign irq = (IRQ_MODE == 0) ? |(data & irq_mask) : |(edge_capture & irq_mask);

endmodule

`default_nettype wire

// File: tb/tb_platform_button_pio.sv
// Testbench for platform_button_pio: table-driven register vectors plus edge/IRQ sequences.
`default_nettype none

module tb_platform_button_pio;

`ifdef PLATFORM_BUTTON_PIO_DEBOUNCE_EN
  localparam int SETTLE = 24;
`else
  localparam int SETTLE = 3;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        chipselect = 1'b0;
  logic [1:0]  address = 2'd0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [3:0]  in_port = 4'h0;
  logic [31:0] readdata0;
  logic [31:0] readdata1;
  logic        irq0;
  logic        irq1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  platform_button_pio #(.WIDTH(4), .EDGE_TYPE(0), .IRQ_MODE(1), .DEBOUNCE_CYCLES(16)) dut0 (
    .clk(clk), .reset_n(reset_n), .chipselect(chipselect), .address(address),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(readdata0), .irq(irq0)
  );

  platform_button_pio #(.WIDTH(4), .EDGE_TYPE(2), .IRQ_MODE(0), .DEBOUNCE_CYCLES(16)) dut1 (
    .clk(clk), .reset_n(reset_n), .chipselect(chipselect), .address(address),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(readdata1), .irq(irq1)
  );

  typedef struct {
    logic [31:0] exp;
    bit          sel;
    string       name;
  } sb_t;

  typedef struct {
    logic [3:0]  in_val;
    bit          wr;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp;
    string       name;
  } vec_t;

  sb_t  sbq[$];
  vec_t vecs[6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    tick();
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic rd(input logic [1:0] a, input logic [31:0] exp, input bit sel, input string name);
    sb_t e;
    address = a;
    e.exp   = exp;
    e.sel   = sel;
    e.name  = name;
    sbq.push_back(e);
    tick();
    e = sbq.pop_front();
    check(e.name, e.sel ? readdata1 : readdata0, e.exp);
  endtask

  initial begin
    vecs[0] = '{in_val: 4'h0, wr: 1'b0, addr: 2'd0, wdata: 32'h0,        exp: 32'h0, name: "data_zero"};
    vecs[1] = '{in_val: 4'h5, wr: 1'b0, addr: 2'd0, wdata: 32'h0,        exp: 32'h5, name: "data_5"};
    vecs[2] = '{in_val: 4'hA, wr: 1'b0, addr: 2'd0, wdata: 32'h0,        exp: 32'hA, name: "data_A"};
    vecs[3] = '{in_val: 4'h0, wr: 1'b1, addr: 2'd1, wdata: 32'hFFFFFFFF, exp: 32'h0, name: "reserved"};
    vecs[4] = '{in_val: 4'h0, wr: 1'b1, addr: 2'd2, wdata: 32'hFFFFFFF6, exp: 32'h6, name: "mask_wr"};
    vecs[5] = '{in_val: 4'h0, wr: 1'b1, addr: 2'd2, wdata: 32'h0,        exp: 32'h0, name: "mask_zero"};

    // Reset with all buttons held high
    in_port = 4'hF;
    repeat (3) tick();
    check("rst_readdata", readdata0, 32'h0);
    check("rst_irq0", {31'b0, irq0}, 32'h0);
    check("rst_irq1", {31'b0, irq1}, 32'h0);
    reset_n = 1'b1;
    #1;
    check("rel_irq0", {31'b0, irq0}, 32'h0);
    repeat (SETTLE) tick();
    rd(2'd0, 32'h0000000F, 1'b0, "rst_data_F");

    for (int i = 0; i < 6; i++) begin
      in_port = vecs[i].in_val;
      if (vecs[i].wr) wr(vecs[i].addr, vecs[i].wdata);
      repeat (SETTLE) tick();
      rd(vecs[i].addr, vecs[i].exp, 1'b0, vecs[i].name);
    end

    wr(2'd3, 32'hF);
    rd(2'd3, 32'h0, 1'b0, "cap_cleared");

`ifdef PLATFORM_BUTTON_PIO_DEBOUNCE_EN
    in_port = 4'h4;
    repeat (10) tick();
    in_port = 4'h0;
    repeat (SETTLE) tick();
    rd(2'd0, 32'h0, 1'b0, "glitch_data");
    rd(2'd3, 32'h0, 1'b0, "glitch_cap");
    in_port = 4'h4;
    repeat (20) tick();
    rd(2'd0, 32'h4, 1'b0, "deb_data");
    rd(2'd3, 32'h4, 1'b0, "deb_cap");
    in_port = 4'h0;
    repeat (SETTLE) tick();
    wr(2'd3, 32'hF);
`endif

    // Masked edge raises irq; write-1-to-clear drops it
    wr(2'd2, 32'h2);
    in_port = 4'h2;
    repeat (SETTLE) tick();
    rd(2'd3, 32'h2, 1'b0, "mask_cap");
    check("mask_irq", {31'b0, irq0}, 32'h1);
    wr(2'd3, 32'h2);
    rd(2'd3, 32'h0, 1'b0, "w1c_cap");
    check("w1c_irq", {31'b0, irq0}, 32'h0);
    in_port = 4'h0;
    repeat (SETTLE) tick();

    // Unmasked edge is captured without irq
    wr(2'd2, 32'h0);
    in_port = 4'h1;
    repeat (SETTLE) tick();
    rd(2'd3, 32'h1, 1'b0, "unmask_cap");
    check("unmask_irq", {31'b0, irq0}, 32'h0);
    in_port = 4'h0;
    repeat (SETTLE) tick();
    wr(2'd3, 32'hF);

`ifndef PLATFORM_BUTTON_PIO_DEBOUNCE_EN
    // Three-cycle capture latency, with a clear landing on the capturing edge
    wr(2'd2, 32'h1);
    in_port = 4'h1;
    tick();
    tick();
    check("lat_irq_early", {31'b0, irq0}, 32'h0);
    wr(2'd3, 32'h1);
    check("setwin_irq", {31'b0, irq0}, 32'h1);
    rd(2'd3, 32'h1, 1'b0, "setwin_cap");
    in_port = 4'h0;
    repeat (SETTLE) tick();
`endif

    // Level IRQ and any-edge capture on the second instance
    wr(2'd2, 32'h1);
    wr(2'd3, 32'hF);
    rd(2'd3, 32'h0, 1'b1, "lvl_cap_clr");
    in_port = 4'h1;
    repeat (SETTLE) tick();
    check("lvl_irq_hi", {31'b0, irq1}, 32'h1);
    in_port = 4'h0;
    repeat (SETTLE) tick();
    check("lvl_irq_lo", {31'b0, irq1}, 32'h0);
    rd(2'd3, 32'h1, 1'b1, "any_edge_cap");
    rd(2'd3, 32'h1, 1'b0, "rise_only_cap");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
